// File: rtl/histeq_pkg.sv
// Shared definitions for the histogram-equalizer master sequencer.
//
// Contents:
//   state_t          - sequencer state; the numeric value is also the encoding
//                      driven on the sequencer's phase output.
//   owner_t          - scratch-memory ownership select for the scratch port mux.
//   DEFAULT_*        - default parameter values for one 256x256 8-bit image.
//   owner_for_state  - which compute phase owns the scratch memory in a state.
//   is_busy_state    - true in the three compute phases.
package histeq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HIST  = 3'd1,
        ST_CDF   = 3'd2,
        ST_DIV   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_HIST = 2'd1,
        OWNER_CDF  = 2'd2,
        OWNER_DIV  = 2'd3
    } owner_t;

    // 256x256 pixels, 16 pixels per 128-bit word.
    localparam int DEFAULT_NUM_INPUT_WORDS = 4096;
    localparam int DEFAULT_CNT_W           = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 65535;

    function automatic owner_t owner_for_state(input state_t s);
        owner_t o;
        case (s)
            ST_HIST: o = OWNER_HIST;
            ST_CDF:  o = OWNER_CDF;
            ST_DIV:  o = OWNER_DIV;
            default: o = OWNER_NONE;
        endcase
        return o;
    endfunction

    function automatic logic is_busy_state(input state_t s);
        return (s == ST_HIST) || (s == ST_CDF) || (s == ST_DIV);
    endfunction

endpackage

// File: rtl/histeq_sat_counter.sv
// Saturating up-counter with synchronous clear and a terminal flag.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous active-low reset; count returns to 0
//   clear    - synchronous clear to 0, has priority over enable
//   enable   - count up by one this cycle (held once LIMIT is reached)
//   terminal - high while the count equals LIMIT
module histeq_sat_counter #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count_reg != LIMIT_W)) begin
            count_next = count_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign terminal = (count_reg == LIMIT_W);

endmodule

// File: rtl/histeq_master_sequencer.sv
// Master controller of the histogram-equalizer core.
//
// Runs histogram -> CDF -> divider for one image per start request, pulses
// each phase's start for one cycle on entry, counts input-memory words read
// during the histogram phase, selects the scratch-memory owner and guards
// every compute phase with a watchdog.
//
// Ports:
//   clock, reset                 - rising-edge clock, async active-low reset
//   start                        - request to process one image (ignored while busy)
//   input_mem_rd_strobe          - one pulse per input word consumed
//   histogram/cdf/divider_computation_done - phase completion, sampled only
//                                  in the matching state
//   start_histogram/cdf/divider  - one-cycle start pulses
//   input_mem_read_finished      - all NUM_INPUT_WORDS read in this histogram phase
//   scratch_owner                - 0 none, 1 histogram, 2 cdf, 3 divider
//   phase                        - current state encoding
//   busy / done / error          - status levels
//
// TIMEOUT_CYCLES must be below 2**CNT_W and NUM_INPUT_WORDS must fit in CNT_W.
module histeq_master_sequencer
    import histeq_pkg::*;
#(
    parameter int NUM_INPUT_WORDS = DEFAULT_NUM_INPUT_WORDS,
    parameter int CNT_W           = DEFAULT_CNT_W,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       input_mem_rd_strobe,
    input  logic       histogram_computation_done,
    input  logic       cdf_computation_done,
    input  logic       divider_computation_done,
    output logic       start_histogram,
    output logic       start_cdf,
    output logic       start_divider,
    output logic       input_mem_read_finished,
    output logic [1:0] scratch_owner,
    output logic [2:0] phase,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_READ = 0;
    localparam int CNT_WDOG = 1;

    state_t     state_reg;
    state_t     state_next;

    logic [1:0] cnt_clear;
    logic [1:0] cnt_enable;
    logic [1:0] cnt_terminal;

    logic       reads_complete;
    logic       watchdog_expired;

    logic       start_histogram_reg, start_histogram_next;
    logic       start_cdf_reg,       start_cdf_next;
    logic       start_divider_reg,   start_divider_next;
    logic       read_finished_reg,   read_finished_next;
    owner_t     owner_reg,           owner_next;
    logic [2:0] phase_reg,           phase_next;
    logic       busy_reg,            busy_next;
    logic       done_reg,            done_next;
    logic       error_reg,           error_next;

    assign reads_complete   = cnt_terminal[CNT_READ];
    assign watchdog_expired = cnt_terminal[CNT_WDOG];

    // ------------------------------------------------------------------
    // Next-state logic. A phase's own done input always beats the
    // watchdog, so completion in the last allowed cycle is not an error.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_HIST;
                end
            end
            ST_HIST: begin
                if (histogram_computation_done) begin
                    state_next = ST_CDF;
                end else if (watchdog_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_CDF: begin
                if (cdf_computation_done) begin
                    state_next = ST_DIV;
                end else if (watchdog_expired) begin
                    state_next = ST_ERROR;
                end
            end
            ST_DIV: begin
                if (divider_computation_done) begin
                    state_next = ST_DONE;
                end else if (watchdog_expired) begin
                    state_next = ST_ERROR;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Counter controls. The read counter is only meaningful inside one
    // histogram phase, so it is zeroed on entry rather than on exit; the
    // watchdog restarts on every state change so each phase gets the full
    // TIMEOUT_CYCLES budget.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_clear             = '0;
        cnt_enable            = '0;
        cnt_clear[CNT_READ]   = (state_next == ST_HIST) && (state_reg != ST_HIST);
        cnt_enable[CNT_READ]  = (state_reg == ST_HIST) && input_mem_rd_strobe;
        cnt_clear[CNT_WDOG]   = (state_next != state_reg);
        cnt_enable[CNT_WDOG]  = is_busy_state(state_reg);
    end

    // Read counter saturates at the word count; the watchdog terminal
    // flag marks the last cycle a phase may spend without completing.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_counter
            localparam int LIMIT = (gi == CNT_READ) ? NUM_INPUT_WORDS : (TIMEOUT_CYCLES - 1);
            histeq_sat_counter #(
                .WIDTH (CNT_W),
                .LIMIT (LIMIT)
            ) u_counter (
                .clock    (clock),
                .reset    (reset),
                .clear    (cnt_clear[gi]),
                .enable   (cnt_enable[gi]),
                .terminal (cnt_terminal[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output decode from the upcoming state so every output is a flop
    // that changes on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_comb begin
        start_histogram_next = (state_next == ST_HIST) && (state_reg != ST_HIST);
        start_cdf_next       = (state_next == ST_CDF)  && (state_reg != ST_CDF);
        start_divider_next   = (state_next == ST_DIV)  && (state_reg != ST_DIV);
        // Staying in HIST with the count already full: the flag follows the
        // count by one cycle and drops as soon as HIST is left.
        read_finished_next   = (state_reg == ST_HIST) && (state_next == ST_HIST) && reads_complete;
        owner_next           = owner_for_state(state_next);
        phase_next           = state_next;
        busy_next            = is_busy_state(state_next);
        done_next            = (state_next == ST_DONE);
        error_next           = (state_next == ST_ERROR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_histogram_reg <= 1'b0;
            start_cdf_reg       <= 1'b0;
            start_divider_reg   <= 1'b0;
            read_finished_reg   <= 1'b0;
            owner_reg           <= OWNER_NONE;
            phase_reg           <= 3'd0;
            busy_reg            <= 1'b0;
            done_reg            <= 1'b0;
            error_reg           <= 1'b0;
        end else begin
            start_histogram_reg <= start_histogram_next;
            start_cdf_reg       <= start_cdf_next;
            start_divider_reg   <= start_divider_next;
            read_finished_reg   <= read_finished_next;
            owner_reg           <= owner_next;
            phase_reg           <= phase_next;
            busy_reg            <= busy_next;
            done_reg            <= done_next;
            error_reg           <= error_next;
        end
    end

    assign start_histogram         = start_histogram_reg;
    assign start_cdf               = start_cdf_reg;
    assign start_divider           = start_divider_reg;
    assign input_mem_read_finished = read_finished_reg;
    assign scratch_owner           = owner_reg;
    assign phase                   = phase_reg;
    assign busy                    = busy_reg;
    assign done                    = done_reg;
    assign error                   = error_reg;

endmodule

// File: tb/tb_histeq_master_sequencer.sv
// Testbench for histeq_master_sequencer. Two instances share all inputs:
// index 0 uses the default parameters, index 1 uses a short watchdog
// (TIMEOUT_CYCLES=8) and a small word count (NUM_INPUT_WORDS=5). A phase-level
// reference model predicts every output of both instances each cycle, and
// directed assertions pin the key scenarios.
module tb_histeq_master_sequencer;

    localparam int P_IDLE = 0;
    localparam int P_HIST = 1;
    localparam int P_CDF  = 2;
    localparam int P_DIV  = 3;
    localparam int P_DONE = 4;
    localparam int P_ERR  = 5;

    localparam int T_P [2] = '{65535, 8};
    localparam int N_P [2] = '{4096, 5};

    logic clock = 1'b0;
    logic reset;
    logic start, rd_strobe, hist_done, cdf_done, div_done;

    logic       o_sh   [2];
    logic       o_sc   [2];
    logic       o_sd   [2];
    logic       o_fin  [2];
    logic [1:0] o_own  [2];
    logic [2:0] o_ph   [2];
    logic       o_busy [2];
    logic       o_done [2];
    logic       o_err  [2];

    int checks = 0;
    int errors = 0;

    // reference model: phase, words read in this histogram phase, cycles spent in phase
    int m_ph [2];
    int m_reads [2];
    int m_age [2];
    int e_sh [2], e_sc [2], e_sd [2], e_fin [2], e_own [2], e_ph [2];
    int e_busy [2], e_done [2], e_err [2];

    always #5 clock = ~clock;

    histeq_master_sequencer u_dut (
        .clock                      (clock),
        .reset                      (reset),
        .start                      (start),
        .input_mem_rd_strobe        (rd_strobe),
        .histogram_computation_done (hist_done),
        .cdf_computation_done       (cdf_done),
        .divider_computation_done   (div_done),
        .start_histogram            (o_sh[0]),
        .start_cdf                  (o_sc[0]),
        .start_divider              (o_sd[0]),
        .input_mem_read_finished    (o_fin[0]),
        .scratch_owner              (o_own[0]),
        .phase                      (o_ph[0]),
        .busy                       (o_busy[0]),
        .done                       (o_done[0]),
        .error                      (o_err[0])
    );

    histeq_master_sequencer #(
        .NUM_INPUT_WORDS (5),
        .CNT_W           (16),
        .TIMEOUT_CYCLES  (8)
    ) u_dut_wd (
        .clock                      (clock),
        .reset                      (reset),
        .start                      (start),
        .input_mem_rd_strobe        (rd_strobe),
        .histogram_computation_done (hist_done),
        .cdf_computation_done       (cdf_done),
        .divider_computation_done   (div_done),
        .start_histogram            (o_sh[1]),
        .start_cdf                  (o_sc[1]),
        .start_divider              (o_sd[1]),
        .input_mem_read_finished    (o_fin[1]),
        .scratch_owner              (o_own[1]),
        .phase                      (o_ph[1]),
        .busy                       (o_busy[1]),
        .done                       (o_done[1]),
        .error                      (o_err[1])
    );

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = P_IDLE; m_reads[k] = 0; m_age[k] = 0;
            e_sh[k] = 0; e_sc[k] = 0; e_sd[k] = 0; e_fin[k] = 0; e_own[k] = 0;
            e_ph[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_err[k] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, from the inputs present at the edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int   old_ph;
            int   new_ph;
            int   old_reads;
            logic own_done;
            old_ph    = m_ph[k];
            new_ph    = old_ph;
            old_reads = m_reads[k];
            if (old_ph == P_IDLE || old_ph == P_DONE || old_ph == P_ERR) begin
                if (start) new_ph = P_HIST;
            end else begin
                own_done = (old_ph == P_HIST) ? hist_done : (old_ph == P_CDF) ? cdf_done : div_done;
                if (own_done) new_ph = old_ph + 1;
                else if (m_age[k] == T_P[k] - 1) new_ph = P_ERR;
            end
            if (new_ph == P_HIST && old_ph != P_HIST) m_reads[k] = 0;
            else if (old_ph == P_HIST && rd_strobe && m_reads[k] < N_P[k]) m_reads[k]++;
            if (new_ph != old_ph) m_age[k] = 0;
            else if (old_ph >= P_HIST && old_ph <= P_DIV) m_age[k]++;
            e_sh[k]   = int'(new_ph == P_HIST && old_ph != P_HIST);
            e_sc[k]   = int'(new_ph == P_CDF && old_ph != P_CDF);
            e_sd[k]   = int'(new_ph == P_DIV && old_ph != P_DIV);
            e_fin[k]  = int'(new_ph == P_HIST && old_ph == P_HIST && old_reads == N_P[k]);
            e_own[k]  = (new_ph >= P_HIST && new_ph <= P_DIV) ? new_ph : 0;
            e_ph[k]   = new_ph;
            e_busy[k] = int'(new_ph >= P_HIST && new_ph <= P_DIV);
            e_done[k] = int'(new_ph == P_DONE);
            e_err[k]  = int'(new_ph == P_ERR);
            m_ph[k]   = new_ph;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("start_histogram", k, 8'(o_sh[k]),   8'(e_sh[k]));
            chk("start_cdf",       k, 8'(o_sc[k]),   8'(e_sc[k]));
            chk("start_divider",   k, 8'(o_sd[k]),   8'(e_sd[k]));
            chk("read_finished",   k, 8'(o_fin[k]),  8'(e_fin[k]));
            chk("scratch_owner",   k, 8'(o_own[k]),  8'(e_own[k]));
            chk("phase",           k, 8'(o_ph[k]),   8'(e_ph[k]));
            chk("busy",            k, 8'(o_busy[k]), 8'(e_busy[k]));
            chk("done",            k, 8'(o_done[k]), 8'(e_done[k]));
            chk("error",           k, 8'(o_err[k]),  8'(e_err[k]));
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are checked there too.
    task automatic step(input logic st, input logic rd, input logic hd, input logic cd, input logic dd);
        start = st; rd_strobe = rd; hist_done = hd; cdf_done = cd; div_done = dd;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int num_reads;
        logic rd;

        start = 0; rd_strobe = 0; hist_done = 0; cdf_done = 0; div_done = 0;
        reset = 1'b0;
        model_reset();
        #2;
        check_all();
        chk("reset_phase", 0, 8'(o_ph[0]), 8'd0);
        chk("reset_owner", 0, 8'(o_own[0]), 8'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;

        // done inputs in IDLE are ignored
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1);
        chk("idle_ignores_done", 0, 8'(o_ph[0]), 8'd0);

        // start -> HIST with a single start_histogram pulse
        step(1, 0, 0, 0, 0);
        chk("start_pulse", 0, 8'(o_sh[0]), 8'd1);
        chk("hist_owner",  0, 8'(o_own[0]), 8'd1);
        chk("hist_busy",   0, 8'(o_busy[0]), 8'd1);
        chk("hist_phase",  0, 8'(o_ph[0]), 8'd1);
        step(0, 0, 0, 0, 0);
        chk("start_pulse_one_cycle", 0, 8'(o_sh[0]), 8'd0);

        // short-watchdog instance: 8 cycles in HIST without done -> ERROR
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
        chk("wd_still_hist", 1, 8'(o_ph[1]), 8'd1);
        step(0, 1, 0, 0, 0);
        chk("wd_timeout_phase", 1, 8'(o_ph[1]), 8'd5);
        chk("wd_timeout_error", 1, 8'(o_err[1]), 8'd1);
        chk("wd_timeout_owner", 1, 8'(o_own[1]), 8'd0);

        // fill the default instance to NUM_INPUT_WORDS with random gaps
        num_reads = 7;
        while (num_reads < 4096) begin
            rd = ($urandom_range(0, 3) != 0);
            step(0, rd, 0, 0, 0);
            if (rd) num_reads++;
        end
        chk("fin_not_yet", 0, 8'(o_fin[0]), 8'd0);
        step(0, 1, 0, 0, 0);
        chk("fin_rise", 0, 8'(o_fin[0]), 8'd1);
        step(0, 1, 0, 0, 0);
        chk("fin_after_extra", 0, 8'(o_fin[0]), 8'd1);
        chk("fin_still_hist", 0, 8'(o_ph[0]), 8'd1);

        // histogram done, held high: one start_cdf pulse only
        step(0, 0, 1, 0, 0);
        chk("cdf_pulse", 0, 8'(o_sc[0]), 8'd1);
        chk("cdf_owner", 0, 8'(o_own[0]), 8'd2);
        chk("fin_low_after_hist", 0, 8'(o_fin[0]), 8'd0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("cdf_no_retrigger", 0, 8'(o_sc[0]), 8'd0);
        chk("cdf_hist_done_ignored", 0, 8'(o_ph[0]), 8'd2);
        for (int i = 0; i < 7; i++) step(0, 0, 1'($urandom_range(0, 1)), 0, 0);
        step(0, 0, 0, 1, 0);
        chk("div_pulse", 0, 8'(o_sd[0]), 8'd1);
        chk("div_owner", 0, 8'(o_own[0]), 8'd3);
        for (int i = 0; i < 19; i++) begin
            step(i == 9, 0, 0, 0, 0);
            if (i == 9) chk("start_in_div_ignored", 0, 8'(o_ph[0]), 8'd3);
        end
        step(0, 0, 0, 0, 1);
        chk("done_phase", 0, 8'(o_ph[0]), 8'd4);
        chk("done_owner", 0, 8'(o_own[0]), 8'd0);
        chk("done_level", 0, 8'(o_done[0]), 8'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("done_held", 0, 8'(o_done[0]), 8'd1);

        // second run clears done; ERROR instance restarts too
        step(1, 0, 0, 0, 0);
        chk("rerun_done_clear", 0, 8'(o_done[0]), 8'd0);
        chk("rerun_pulse",      0, 8'(o_sh[0]), 8'd1);
        chk("rerun_from_error", 1, 8'(o_ph[1]), 8'd1);
        chk("rerun_error_clear", 1, 8'(o_err[1]), 8'd0);

        // done in the watchdog's last cycle wins
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("done_beats_timeout_phase", 1, 8'(o_ph[1]), 8'd2);
        chk("done_beats_timeout_err",   1, 8'(o_err[1]), 8'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("cdf_ignores_hist_done", 0, 8'(o_ph[0]), 8'd2);

        // asynchronous reset mid-CDF
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_reset_phase", 0, 8'(o_ph[0]), 8'd0);
        chk("async_reset_owner", 0, 8'(o_own[0]), 8'd0);
        start = 0; rd_strobe = 0; hist_done = 0; cdf_done = 0; div_done = 0;
        repeat (2) begin
            @(posedge clock);
            #1;
            check_all();
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("post_reset_no_pulse", 0, 8'(o_sh[0]), 8'd0);
        chk("post_reset_idle",     0, 8'(o_ph[0]), 8'd0);
        step(1, 0, 0, 0, 0);
        chk("post_reset_start", 0, 8'(o_sh[0]), 8'd1);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/histeq_master_sequencer.md
Name: histeq_master_sequencer

Overview:
- Master controller for the histogram-equalizer core. Sequences the three compute phases in order: histogram, CDF, divider.
- Issues one-cycle start pulses to each phase and counts input-memory word reads to generate input_mem_read_finished.
- Drives the scratch-memory ownership select used by the scratch-memory port mux.
- Runs a per-phase watchdog and reports busy/done/error to the top level.

Parameters:
NUM_INPUT_WORDS, 4096, number of 128-bit input-memory words per image (256x256 8-bit pixels / 16 per word)
CNT_W, 16, width of the read counter and watchdog counter
TIMEOUT_CYCLES, 65535, cycles allowed per phase before error; must be < 2**CNT_W

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  level/pulse request to process one image
input_mem_rd_strobe  in  1  one pulse per input-memory word accepted by the histogram datapath
histogram_computation_done  in  1  histogram phase complete
cdf_computation_done  in  1  CDF phase complete
divider_computation_done  in  1  divider phase complete
start_histogram  out  1  one-cycle start pulse
start_cdf  out  1  one-cycle start pulse
start_divider  out  1  one-cycle start pulse
input_mem_read_finished  out  1  all NUM_INPUT_WORDS read in current histogram phase
scratch_owner  out  2  0 none, 1 histogram, 2 cdf, 3 divider
phase  out  3  encoded current state
busy  out  1  high in HIST/CDF/DIV
done  out  1  high in DONE
error  out  1  high in ERROR

Behaviour:
- All outputs are registered. While reset=0: state IDLE, all 1-bit outputs 0, scratch_owner=0, phase=0, both counters 0. Reset asserted mid-phase aborts immediately to these values.
- States and phase encoding: IDLE=0, HIST=1, CDF=2, DIV=3, DONE=4, ERROR=5.
- IDLE, DONE or ERROR with start=1 at edge t -> HIST at t+1. The same cycle, start_histogram=1 and scratch_owner=1; done/error clear.
- start while busy is ignored.
- HIST with histogram_computation_done=1 -> CDF; start_cdf pulses and scratch_owner=2 the same cycle.
- CDF with cdf_computation_done=1 -> DIV; start_divider pulses and scratch_owner=3.
- DIV with divider_computation_done=1 -> DONE; scratch_owner=0.
- Each start_* pulse is exactly one cycle, only on entry to its state.
- Done inputs are sampled only in the matching state; a done input in any other state is ignored. A done input held high does not re-trigger.
- Read counter:
  - Cleared on entry to HIST.
  - Increments on input_mem_rd_strobe only in HIST; saturates at NUM_INPUT_WORDS and ignores extra strobes.
  - input_mem_read_finished=1 from the cycle after the count reaches NUM_INPUT_WORDS until HIST is exited. Low outside HIST.
- Watchdog:
  - Cleared on every state entry; increments each cycle in HIST/CDF/DIV.
  - At count == TIMEOUT_CYCLES-1 with no matching done -> ERROR at next edge; scratch_owner=0.
  - A matching done in the timeout cycle wins: normal transition, no error.
- DONE and ERROR are held as levels until the next start or reset.

Decomposition:
- Shared package histeq_pkg holds:
  - state encoding constants
  - scratch_owner encoding (OWNER_NONE/HIST/CDF/DIV)
  - default NUM_INPUT_WORDS
- One sub-module, histeq_sat_counter: clear, enable, saturating limit, terminal flag. It is instantiated twice, as the read counter and the watchdog.

Test Plan:
- Reset, start=1 for 1 cycle -> next cycle start_histogram=1 (exactly 1 cycle), scratch_owner=1, busy=1, phase=1.
- In HIST, 4096 strobes -> input_mem_read_finished rises the cycle after the 4096th. A 4097th strobe changes nothing. histogram done -> start_cdf pulse, owner=2.
- Full run with cdf done after 10 cycles and divider done after 20 -> owner sequence 1,2,3,0; done=1 held. A second start -> new run with done cleared.
- TIMEOUT_CYCLES=8, no histogram done -> error=1 and phase=5 after 8 cycles in HIST, owner=0. Then start -> HIST.
- histogram_computation_done asserted in IDLE and during CDF -> ignored, no state change. start pulsed during DIV -> ignored.
- reset=0 asserted mid-CDF -> all outputs 0 asynchronously. After release, no start pulses until start=1.
